// File: rtl/axi_stream_pkg.sv
// Shared types and helpers for the AXI-stream FIFO slice.
//   beat_t          : one stored beat {start, last, data} at the default data width
//   ptr_w()         : pointer width (address bits plus one wrap bit) for a given depth
//   frame_violation : framing rule check for an accepted input beat
package axi_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      start;
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } beat_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // A start inside an open frame means the previous last was lost; a non-start
  // beat outside a frame means the start was lost.
  function automatic logic frame_violation(input logic start, input logic frame_open);
    return (start && frame_open) || (!start && !frame_open);
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// AXI-stream style interface: data plus start/last framing, valid/ready handshake.
//   master modport drives data/valid/start/last and samples ready
//   slave  modport samples data/valid/start/last and drives ready
interface axi_stream_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  start;
  logic                  last;

  modport master (output data, output valid, output start, output last, input ready);
  modport slave  (input data, input valid, input start, input last, output ready);
endinterface

// File: rtl/axi_stream_fifo_mem.sv
// Register-array storage for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
module axi_stream_fifo_mem #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_stream_fifo.sv
// First-word-fall-through FIFO with start/last framing side-band.
//   clk, rst_n   : clock, asynchronous active-low reset
//   s_axis       : input stream (slave side)
//   m_axis       : output stream (master side)
//   level_o      : beats stored, 0..DEPTH
//   frames_o     : stored beats carrying last=1
//   frame_err_o  : sticky framing error
//   clr_err_i    : synchronous clear of frame_err_o (a same-cycle new error wins)
module axi_stream_fifo
  import axi_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_stream_if.slave      s_axis,
  axi_stream_if.master     m_axis,
  output logic [CNT_W-1:0] level_o,
  output logic [CNT_W-1:0] frames_o,
  output logic             frame_err_o,
  input  logic             clr_err_i
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned BW = DATA_WIDTH + 2;
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             frame_open_q, frame_open_d;
  logic             frame_err_q, frame_err_d;
  logic             full_s, empty_s, wr_en_s, rd_en_s;
  logic [BW-1:0]    wr_beat_s, rd_beat_s;

  // Same address with differing wrap bits means the writer lapped the reader.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign s_axis.ready = ~full_s;
  assign m_axis.valid = ~empty_s;
  assign wr_en_s      = s_axis.valid & ~full_s;
  assign rd_en_s      = m_axis.ready & ~empty_s;
  assign wr_beat_s    = {s_axis.start, s_axis.last, s_axis.data};

  assign level_o     = CNT_W'(wr_ptr_q - rd_ptr_q);
  assign frames_o    = frames_q;
  assign frame_err_o = frame_err_q;

  axi_stream_fifo_mem #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_beat_s),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_beat_s)
  );

  // Output beat: memory head while valid, zero otherwise (memory is never reset).
  always_comb begin
    m_axis.start = 1'b0;
    m_axis.last  = 1'b0;
    m_axis.data  = '0;
    if (!empty_s) begin
      {m_axis.start, m_axis.last, m_axis.data} = rd_beat_s;
    end else begin
      {m_axis.start, m_axis.last, m_axis.data} = '0;
    end
  end

  // Next-state for pointers, frame counter and framing checker.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frames_d     = frames_q;
    frame_open_d = frame_open_q;
    frame_err_d  = frame_err_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Incoming and outgoing last beats cancel each other.
    case ({wr_en_s & s_axis.last, rd_en_s & rd_beat_s[BW-2]})
      2'b10:   frames_d = frames_q + CNT_ONE;
      2'b01:   frames_d = frames_q - CNT_ONE;
      default: frames_d = frames_q;
    endcase

    // last closes the frame even when start is also set (single-beat frame).
    if (wr_en_s && s_axis.last) begin
      frame_open_d = 1'b0;
    end else if (wr_en_s && s_axis.start) begin
      frame_open_d = 1'b1;
    end else begin
      frame_open_d = frame_open_q;
    end

    if (wr_en_s && frame_violation(s_axis.start, frame_open_q)) begin
      frame_err_d = 1'b1;
    end else if (clr_err_i) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frames_q     <= '0;
      frame_open_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frames_q     <= frames_d;
      frame_open_q <= frame_open_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Self-checking bench for axi_stream_fifo: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_axi_stream_fifo;
  import axi_stream_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] level, frames;
  logic          frame_err;

  axi_stream_if #(.DATA_WIDTH(DW)) s_if ();
  axi_stream_if #(.DATA_WIDTH(DW)) m_if ();

  axi_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .level_o     (level),
    .frames_o    (frames),
    .frame_err_o (frame_err),
    .clr_err_i   (clr_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  beat_t q[$];
  int    frames_m = 0;
  bit    err_m = 1'b0;
  bit    open_m = 1'b0;
  int    wr_cnt = 0;
  int    rd_cnt = 0;

  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit st, input bit ls, input logic [DW-1:0] d,
                       input bit mr, input bit clr);
    s_if.valid = v;
    s_if.start = st;
    s_if.last  = ls;
    s_if.data  = d;
    m_if.ready = mr;
    clr_err    = clr;
  endtask

  task automatic check_outputs();
    check_eq("m_valid", {63'd0, m_if.valid}, {63'd0, q.size() != 0});
    check_eq("s_ready", {63'd0, s_if.ready}, {63'd0, q.size() != DEPTH});
    check_eq("level", 64'(level), 64'(q.size()));
    check_eq("frames", 64'(frames), 64'(frames_m));
    check_eq("frame_err", {63'd0, frame_err}, {63'd0, err_m});
    if (q.size() != 0) begin
      check_eq("m_data", 64'(m_if.data), 64'(q[0].data));
      check_eq("m_start", {63'd0, m_if.start}, {63'd0, q[0].start});
      check_eq("m_last", {63'd0, m_if.last}, {63'd0, q[0].last});
    end else begin
      check_eq("m_idle_beat", 64'({m_if.start, m_if.last, m_if.data}), 64'd0);
    end
  endtask

  // One clock: model follows the spec rules using pre-edge inputs, then outputs are checked.
  task automatic tick();
    bit    do_wr, do_rd, viol;
    beat_t nb;
    do_wr = s_if.valid && (q.size() < DEPTH);
    do_rd = m_if.ready && (q.size() > 0);
    nb.start = s_if.start;
    nb.last  = s_if.last;
    nb.data  = s_if.data;
    viol = do_wr && (nb.start ? open_m : !open_m);
    @(posedge clk);
    if (do_rd) begin
      if (q[0].last) frames_m--;
      void'(q.pop_front());
      rd_cnt++;
    end
    if (do_wr) begin
      q.push_back(nb);
      if (nb.last) frames_m++;
      open_m = nb.last ? 1'b0 : (nb.start ? 1'b1 : open_m);
      wr_cnt++;
    end
    if (viol) err_m = 1'b1;
    else if (clr_err) err_m = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_clear();
    q.delete();
    frames_m = 0;
    err_m    = 1'b0;
    open_m   = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    logic [7:0]    st_bits, ls_bits;
    logic [DW-1:0] held;
    bit            pend;

    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_eq("rst_valid", {63'd0, m_if.valid}, 64'd0);
    check_eq("rst_ready", {63'd0, s_if.ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // 1: reset mid-stream at level 5
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
      tick();
    end
    check_eq("pre_rst_level", 64'(level), 64'd5);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid_drop", {63'd0, m_if.valid}, 64'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("post_rst_level", 64'(level), 64'd0);
    check_eq("post_rst_frames", 64'(frames), 64'd0);
    check_eq("post_rst_ready", {63'd0, s_if.ready}, 64'd1);
    check_outputs();

    // 2: fill to full, 17th beat held
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
      tick();
    end
    check_eq("full_ready", {63'd0, s_if.ready}, 64'd0);
    check_eq("full_level", 64'(level), 64'd16);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, DW'(32'h10), 1'b0, 1'b0);
      tick();
    end
    check_eq("held_level", 64'(level), 64'd16);

    // 3: full + read in the same cycle
    check_eq("head_0", 64'(m_if.data), 64'd0);
    drive(1'b1, 1'b1, 1'b1, DW'(32'h10), 1'b1, 1'b0);
    tick();
    check_eq("full_read_level", 64'(level), 64'd15);
    drive(1'b1, 1'b1, 1'b1, DW'(32'h10), 1'b0, 1'b0);
    tick();
    check_eq("refill_level", 64'(level), 64'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("drain_order", 64'(m_if.data), 64'(i + 1));
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    check_eq("drained_level", 64'(level), 64'd0);

    // 4: streaming, both sides always ready
    do_reset();
    wr_cnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < 101; i++) begin
      drive(i < 100, 1'b1, 1'b1, DW'($urandom), 1'b1, 1'b0);
      tick();
      check_eq("stream_level_le1", {63'd0, level <= CW'(1)}, 64'd1);
    end
    check_eq("stream_writes", 64'(wr_cnt), 64'd100);
    check_eq("stream_reads", 64'(rd_cnt), 64'd100);

    // 5: frames of 3, 1 and 4 beats
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) || (i == 3) || (i == 4), (i == 2) || (i == 3) || (i == 7),
            DW'(32'h50 + i), 1'b0, 1'b0);
      tick();
    end
    check_eq("frames_3", 64'(frames), 64'd3);
    check_eq("frames_level", 64'(level), 64'd8);
    for (int i = 0; i < 8; i++) begin
      st_bits[i] = m_if.start;
      ls_bits[i] = m_if.last;
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    check_eq("start_positions", 64'(st_bits), 64'h19);
    check_eq("last_positions", 64'(ls_bits), 64'h8C);
    check_eq("frames_zero", 64'(frames), 64'd0);

    // 6: framing errors
    do_reset();
    drive(1'b1, 1'b1, 1'b0, DW'(1), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, DW'(2), 1'b0, 1'b0); tick();
    check_eq("no_err_yet", {63'd0, frame_err}, 64'd0);
    drive(1'b1, 1'b1, 1'b0, DW'(3), 1'b0, 1'b0); tick();
    check_eq("err_missing_last", {63'd0, frame_err}, 64'd1);
    check_eq("err_beats_kept", 64'(level), 64'd3);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1); tick();
    check_eq("err_cleared", {63'd0, frame_err}, 64'd0);
    drive(1'b1, 1'b0, 1'b1, DW'(4), 1'b0, 1'b0); tick();
    check_eq("close_ok", {63'd0, frame_err}, 64'd0);
    drive(1'b1, 1'b0, 1'b0, DW'(5), 1'b0, 1'b0); tick();
    check_eq("err_missing_start", {63'd0, frame_err}, 64'd1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1); tick();
    check_eq("err_cleared2", {63'd0, frame_err}, 64'd0);
    drive(1'b1, 1'b0, 1'b0, DW'(6), 1'b0, 1'b1); tick();
    check_eq("set_wins_clear", {63'd0, frame_err}, 64'd1);

    // Random traffic; upstream holds its beat while stalled.
    do_reset();
    pend = 1'b0;
    held = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        held = DW'($urandom);
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              held, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      end else begin
        m_if.ready = $urandom_range(0, 2) != 0;
        clr_err    = $urandom_range(0, 9) == 0;
      end
      pend = s_if.valid && !s_if.ready;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
